multi_cycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle CPU. It decodes the 6-bit opcode over successive cycles and sequences the shared datapath: the 5-bit register-destination mux (rt/rd select), register-file write, unified memory, IR/PC writes, ALU operand muxes and PC source mux. It sits beside the datapath top level and owns every datapath control line. Memory accesses use a ready handshake so variable-latency memory can stall the sequence.

---
 rtl/multi_cycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU: fetch/decode/execute sequencing of
// the shared datapath, with ready-handshaked memory stalls in IF, MEM_RD and MEM_WR.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_IF       = 4'd1;
    localparam logic [3:0] S_ID       = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_LW_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EX_R     = 4'd7;
    localparam logic [3:0] S_WB_R     = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_ADDI_EX  = 4'd11;
    localparam logic [3:0] S_ADDI_WB  = 4'd12;

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_IF;
            S_IF:       if (mem_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EX_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_IF;
                endcase
            end
            // Only LW and SW reach MEM_ADDR, so anything but LW is a store.
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_LW_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_IF;
            S_EX_R:     state_d = S_WB_R;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_LW_WB, S_WB_R, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_IF;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                illegal   = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle vector table through a scoreboard queue,
// plus asynchronous mid-instruction reset sequences.
module tb_multi_cycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       reg_dst, reg_write, mem_read, mem_write, i_or_d, mem_to_reg;
    logic       ir_write, pc_write, pc_write_cond, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    // Output word: {reg_dst, reg_write, mem_read, mem_write, i_or_d, mem_to_reg,
    // ir_write, pc_write, pc_write_cond, alu_src_a, alu_src_b, alu_op, pc_source,
    // instr_done, illegal}
    logic [17:0] outs;
    assign outs = {reg_dst, reg_write, mem_read, mem_write, i_or_d, mem_to_reg,
                   ir_write, pc_write, pc_write_cond, alu_src_a, alu_src_b,
                   alu_op, pc_source, instr_done, illegal};

    localparam logic [17:0] B_RDST  = 18'h20000;
    localparam logic [17:0] B_RWR   = 18'h10000;
    localparam logic [17:0] B_MRD   = 18'h08000;
    localparam logic [17:0] B_MWR   = 18'h04000;
    localparam logic [17:0] B_IORD  = 18'h02000;
    localparam logic [17:0] B_M2R   = 18'h01000;
    localparam logic [17:0] B_IRW   = 18'h00800;
    localparam logic [17:0] B_PCW   = 18'h00400;
    localparam logic [17:0] B_PCWC  = 18'h00200;
    localparam logic [17:0] B_SRCA  = 18'h00100;
    localparam logic [17:0] B_SB_4  = 18'h00040;
    localparam logic [17:0] B_SB_IM = 18'h00080;
    localparam logic [17:0] B_SB_SH = 18'h000C0;
    localparam logic [17:0] B_OPSUB = 18'h00010;
    localparam logic [17:0] B_OPFN  = 18'h00020;
    localparam logic [17:0] B_PS_AO = 18'h00004;
    localparam logic [17:0] B_PS_J  = 18'h00008;
    localparam logic [17:0] B_DONE  = 18'h00002;
    localparam logic [17:0] B_ILL   = 18'h00001;

    localparam logic [17:0] O_NONE  = 18'h0;
    localparam logic [17:0] O_IFS   = B_MRD | B_SB_4;
    localparam logic [17:0] O_IFG   = B_MRD | B_SB_4 | B_IRW | B_PCW;
    localparam logic [17:0] O_ID    = B_SB_SH;
    localparam logic [17:0] O_IDI   = B_SB_SH | B_ILL;
    localparam logic [17:0] O_ADDR  = B_SRCA | B_SB_IM;
    localparam logic [17:0] O_MRD   = B_MRD | B_IORD;
    localparam logic [17:0] O_LWWB  = B_RWR | B_M2R | B_DONE;
    localparam logic [17:0] O_MWRS  = B_MWR | B_IORD;
    localparam logic [17:0] O_MWRG  = B_MWR | B_IORD | B_DONE;
    localparam logic [17:0] O_EXR   = B_SRCA | B_OPFN;
    localparam logic [17:0] O_WBR   = B_RDST | B_RWR | B_DONE;
    localparam logic [17:0] O_BR    = B_SRCA | B_OPSUB | B_PCWC | B_PS_AO | B_DONE;
    localparam logic [17:0] O_JMP   = B_PCW | B_PS_J | B_DONE;
    localparam logic [17:0] O_AWB   = B_RWR | B_DONE;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] out;
        string       name;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [17:0] out);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.out = out;
        tbl.push_back(v);
    endtask

    // Drive one cycle, push the expectation, compare on the falling edge.
    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [17:0] out);
        exp_t e;
        opcode = op; mem_ready = rdy;
        e.st = st; e.out = out; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, ".state"}, {28'd0, state}, {28'd0, e.st});
        chk({e.name, ".outs"}, {14'd0, outs}, {14'd0, e.out});
        @(posedge clk); #1;
    endtask

    initial begin
        // R-type, mem_ready ignored outside memory states
        add(R,    1'b0, 4'd0,  O_NONE);
        add(R,    1'b1, 4'd1,  O_IFG);
        add(R,    1'b0, 4'd2,  O_ID);
        add(R,    1'b0, 4'd7,  O_EXR);
        add(R,    1'b0, 4'd8,  O_WBR);
        // LW with two stall cycles in MEM_RD
        add(LW,   1'b1, 4'd1,  O_IFG);
        add(LW,   1'b1, 4'd2,  O_ID);
        add(LW,   1'b0, 4'd3,  O_ADDR);
        add(LW,   1'b0, 4'd4,  O_MRD);
        add(LW,   1'b0, 4'd4,  O_MRD);
        add(LW,   1'b1, 4'd4,  O_MRD);
        add(LW,   1'b0, 4'd5,  O_LWWB);
        // SW, no stall
        add(SW,   1'b1, 4'd1,  O_IFG);
        add(SW,   1'b1, 4'd2,  O_ID);
        add(SW,   1'b1, 4'd3,  O_ADDR);
        add(SW,   1'b1, 4'd6,  O_MWRG);
        // ADDI
        add(ADDI, 1'b1, 4'd1,  O_IFG);
        add(ADDI, 1'b0, 4'd2,  O_ID);
        add(ADDI, 1'b0, 4'd11, O_ADDR);
        add(ADDI, 1'b0, 4'd12, O_AWB);
        // IF stall x3 then illegal opcode
        add(BAD,  1'b0, 4'd1,  O_IFS);
        add(BAD,  1'b0, 4'd1,  O_IFS);
        add(BAD,  1'b0, 4'd1,  O_IFS);
        add(BAD,  1'b1, 4'd1,  O_IFG);
        add(BAD,  1'b1, 4'd2,  O_IDI);
        // BEQ then J back-to-back
        add(BEQ,  1'b1, 4'd1,  O_IFG);
        add(BEQ,  1'b1, 4'd2,  O_ID);
        add(BEQ,  1'b0, 4'd9,  O_BR);
        add(J,    1'b1, 4'd1,  O_IFG);
        add(J,    1'b1, 4'd2,  O_ID);
        add(J,    1'b0, 4'd10, O_JMP);
        // SW with one stall in MEM_WR
        add(SW,   1'b1, 4'd1,  O_IFG);
        add(SW,   1'b0, 4'd2,  O_ID);
        add(SW,   1'b0, 4'd3,  O_ADDR);
        add(SW,   1'b0, 4'd6,  O_MWRS);
        add(SW,   1'b1, 4'd6,  O_MWRG);
        add(R,    1'b0, 4'd1,  O_IFS);

        reset = 1'b1; opcode = R; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", {28'd0, state}, 32'd0);
        chk("reset.outs", {14'd0, outs}, 32'd0);
        reset = 1'b0;

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].out);

        // Async reset mid-EX_R, with mem_ready high to exercise the Mealy paths
        step("rst_if", R, 1'b1, 4'd1, O_IFG);
        step("rst_id", R, 1'b1, 4'd2, O_ID);
        #2 reset = 1'b1;
        #1;
        chk("rst_exr.state", {28'd0, state}, 32'd0);
        chk("rst_exr.reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_exr.outs", {14'd0, outs}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold.state", {28'd0, state}, 32'd0);
        reset = 1'b0;
        step("rst_rel0", R, 1'b1, 4'd0, O_NONE);
        step("rst_rel1", R, 1'b1, 4'd1, O_IFG);
        // Reset during WB_R drops reg_write immediately
        step("rst2_id", R, 1'b1, 4'd2, O_ID);
        step("rst2_ex", R, 1'b1, 4'd7, O_EXR);
        #2;
        chk("rst2_wbr.reg_write_pre", {31'd0, reg_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst2_wbr.state", {28'd0, state}, 32'd0);
        chk("rst2_wbr.outs", {14'd0, outs}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step("rst2_rel0", R, 1'b0, 4'd0, O_NONE);
        step("rst2_rel1", R, 1'b0, 4'd1, O_IFS);

        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
